// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MIPS mult/multu/div/divu unit holding HI/LO
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_accept;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_zero;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_mag;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_busy;
    logic               r_done;
    logic               r_divzero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_signed;
    logic               w_sa;
    logic               w_sb;
    logic               w_start_zero;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Magnitudes taken modulo 2^WIDTH, so 0x80000000 stays a valid unsigned magnitude.
    assign w_signed     = ~op[0];
    assign w_sa         = w_signed & a[WIDTH-1];
    assign w_sb         = w_signed & b[WIDTH-1];
    assign w_mag_a      = w_sa ? -a : a;
    assign w_mag_b      = w_sb ? -b : b;
    assign w_start_zero = op[1] & (b == '0);

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide keeps remainder in the upper half and shifts quotient bits into the lower half.
    assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff  = w_div_shift - {1'b0, r_mag};
    assign w_div_next  = w_div_diff[WIDTH]
                       ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                       : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !cancel) begin
                    w_accept     = 1'b1;
                    w_next_state = w_start_zero ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (cancel) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_next_state = S_FIX;
                end
            end
            S_FIX:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_zero    <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_mag     <= '0;
            r_acc     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mthi) r_hi <= wdata;
                    if (mtlo) r_lo <= wdata;
                    if (w_accept) begin
                        r_is_div  <= op[1];
                        r_zero    <= w_start_zero;
                        r_neg_q   <= w_sa ^ w_sb;
                        r_neg_r   <= w_sa;
                        r_mag     <= op[1] ? w_mag_b : w_mag_a;
                        r_acc     <= {{WIDTH{1'b0}}, (op[1] ? w_mag_a : w_mag_b)};
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_divzero <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (cancel) begin
                        r_busy <= 1'b0;
                    end else begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    r_busy <= 1'b0;
                    if (!cancel) begin
                        r_done <= 1'b1;
                        if (r_zero) begin
                            r_divzero <= 1'b1;
                        end else if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign divzero = r_divzero;
    assign hi      = r_hi;
    assign lo      = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        divzero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .cancel  (cancel),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .divzero (divzero),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is high (or the budget ran out).
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int cycles);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start  = 1'b0;
        cycles = 0;
        while (!done && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        if (!done) check("done_timeout", 32'(cycles), 32'd0);
    endtask

    int  cyc;
    int  wait_cnt;
    logic saw_done;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;
        cancel = 1'b0;
        mthi   = 1'b0;
        mtlo   = 1'b0;
        wdata  = '0;
        repeat (2) @(negedge clk);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_divzero", 32'(divzero), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        check("multu_busy_cycles", 32'(cyc), 32'd33);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);
        check("multu_busy_at_done", 32'(busy), 32'h0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'h0);

        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, cyc);
        check("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", lo, 32'hFFFF_FFEB);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
        check("b2b_div_cycles", 32'(cyc), 32'd33);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);

        run_op(OP_DIVU, 32'd100, 32'd7, cyc);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);
        check("divu_divzero", 32'(divzero), 32'h0);
        run_op(OP_DIV, 32'd5, 32'd0, cyc);
        check("div0_cycles", 32'(cyc), 32'd1);
        check("div0_flag", 32'(divzero), 32'h1);
        check("div0_hi_kept", hi, 32'd2);
        check("div0_lo_kept", lo, 32'd14);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        check("divmin_lo", lo, 32'h8000_0000);
        check("divmin_hi", hi, 32'h0);
        check("divmin_flag_cleared", 32'(divzero), 32'h0);

        run_op(OP_MULT, 32'h8000_0000, 32'd2, cyc);
        check("multmin_hi", hi, 32'hFFFF_FFFF);
        check("multmin_lo", lo, 32'h0);
        @(negedge clk);

        // Start and mtlo while busy must both be dropped.
        start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd2;
        mtlo = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0;
        wait_cnt = 0;
        while (!done && wait_cnt < 100) begin
            wait_cnt++;
            @(negedge clk);
        end
        check("ignore_done_seen", 32'(done), 32'h1);
        check("ignore_hi", hi, 32'h0);
        check("ignore_lo", lo, 32'd15);
        @(negedge clk);
        check("ignore_no_second_op", 32'(busy), 32'h0);

        mtlo = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        mtlo = 1'b0;
        check("mtlo_idle_lo", lo, 32'h1234);
        check("mtlo_idle_hi", hi, 32'h0);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hABCD;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("mthilo_hi", hi, 32'hABCD);
        check("mthilo_lo", lo, 32'hABCD);

        start = 1'b1; op = OP_MULTU; a = 32'hFFFF; b = 32'hFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", 32'(busy), 32'h0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        check("cancel_no_done", 32'(saw_done), 32'h0);
        check("cancel_hi", hi, 32'hABCD);
        check("cancel_lo", lo, 32'hABCD);

        start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_hi", hi, 32'h0);
        check("arst_lo", lo, 32'h0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        run_op(OP_DIVU, 32'd1000, 32'd3, cyc);
        check("post_rst_lo", lo, 32'd333);
        check("post_rst_hi", hi, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage, alongside the ALU, fed by the same 32-bit operand buses a and b.
- Executes MIPS mult, multu, div and divu over multiple cycles and holds the architectural HI/LO registers.
- HI/LO are read downstream by mfhi/mflo in parallel with the ALU result.
- The busy output stalls the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO register width. Only 32 is supported; it sets the iteration count.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new operation; sampled only when busy=0
- op  input  2  00 mult, 01 multu, 10 div, 11 divu
- a  input  32  rs operand (multiplicand / dividend)
- b  input  32  rt operand (multiplier / divisor)
- cancel  input  1  pipeline flush; aborts an in-flight operation
- mthi  input  1  write wdata to HI
- mtlo  input  1  write wdata to LO
- wdata  input  32  data for mthi/mtlo
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO have just been updated by an operation
- divzero  output  1  sticky flag: the last completed div/divu had b=0
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset:
  - The design uses one clock. Reset is asynchronous and active-low.
  - While rst_n=0: hi=0, lo=0, busy=0, done=0, divzero=0, FSM in IDLE.
  - Reset mid-operation discards the operation with no HI/LO update.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - If start=1 on a clock edge, capture op, capture a/b magnitudes (absolute values for signed ops, raw values for unsigned ops), capture the result sign bits, clear the iteration counter, set busy=1, and go to RUN.
  - divzero is cleared on acceptance of any op.
  - Divide by zero (div/divu with b=0): go directly to FIX with the zero flag set.
- RUN:
  - One radix-2 step per cycle for 32 cycles. Counter runs 0..31; at count 31, go to FIX.
  - Multiply: shift-add into a 64-bit product.
  - Divide: restoring shift-subtract into a 32-bit quotient and 32-bit remainder.
- FIX (1 cycle):
  - Apply sign correction. Product is negated if sign(a)^sign(b) for mult. Quotient is negated if sign(a)^sign(b) for div. Remainder takes the sign of a.
  - Write HI/LO: multiply gives {hi,lo} = 64-bit product; divide gives lo = quotient, hi = remainder.
  - Divide by zero: HI/LO are left unchanged and divzero is set to 1.
  - Then busy=0, done=1 for exactly the following cycle, and the FSM returns to IDLE.
- Latency:
  - Start accepted at edge E0. HI/LO are written at edge E33. busy is high for the cycles between E0 and E33. done is high in the cycle after E33.
  - Divide by zero: done is high after E1.
- Back-to-back: start may be asserted in the same cycle done=1. It is accepted because busy=0.
- start while busy=1: ignored, no queuing.
- cancel:
  - When busy=1: on the next edge go to IDLE, busy=0, no done pulse, HI/LO unchanged.
  - When idle: no effect. cancel overrides a simultaneous start.
- mthi/mtlo:
  - Honoured only when busy=0; ignored while busy.
  - If mthi or mtlo arrives in the same cycle as an accepted start, the write happens and the later operation result overwrites it.
  - If mthi and mtlo are both asserted, both registers are written.
- Arithmetic:
  - All results wrap modulo 2^32 per register.
  - div of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0, with no flag and no exception.
  - Magnitude of 0x80000000 is handled with a 33-bit intermediate or by unsigned interpretation, so it must not corrupt the result.
- Outputs hi/lo/busy/done/divzero are driven directly from registers, with no combinational path from the inputs.

Test Plan:
- multu a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- mult a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then div a=0xFFFFFFF9(-7) b=2 back-to-back on the done cycle -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=100 b=7 -> lo=14, hi=2, divzero=0. Then div a=5 b=0 -> done after 1 cycle, divzero=1, HI/LO still 2/14. Then div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Pulse start again during busy with different operands, and assert mtlo wdata=0x1234 during busy -> both ignored; the original result is written. mtlo while idle -> lo=0x1234 next cycle.
- cancel at cycle 10 of a multu -> busy=0 next cycle, no done pulse, HI/LO unchanged.
- rst_n low for less than one cycle mid-divide, asynchronous to clk -> all outputs 0 immediately; a new start after release completes normally.
